// File: rtl/fbosc_seq_pkg.sv
// Shared types and reset constants for the fbosc_seq swap-pair sequencer.
package fbosc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Per-bit reset patterns; replicate to any width as {W{Y*_RST_BIT}}.
    localparam logic Y1_RST_BIT = 1'b0;
    localparam logic Y2_RST_BIT = 1'b1;

    function automatic logic [63:0] y1_rst64();
        return {64{Y1_RST_BIT}};
    endfunction

    function automatic logic [63:0] y2_rst64();
        return {64{Y2_RST_BIT}};
    endfunction

endpackage

// File: rtl/fbosc_pair.sv
// Two W-bit registers that either load a seed pair or swap contents; no control logic.
module fbosc_pair
    import fbosc_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         swap_i,
    input  logic [W-1:0] seed1_i,
    input  logic [W-1:0] seed2_i,
    output logic [W-1:0] y1_o,
    output logic [W-1:0] y2_o
);

    logic [W-1:0] y1_q, y1_d;
    logic [W-1:0] y2_q, y2_d;

    // Load wins over swap so a reseed is never mixed with a swap.
    always_comb begin
        y1_d = y1_q;
        y2_d = y2_q;
        if (load_i) begin
            y1_d = seed1_i;
            y2_d = seed2_i;
        end else if (swap_i) begin
            y1_d = y2_q;
            y2_d = y1_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            y1_q <= {W{Y1_RST_BIT}};
            y2_q <= {W{Y2_RST_BIT}};
        end else begin
            y1_q <= y1_d;
            y2_q <= y2_d;
        end
    end

    assign y1_o = y1_q;
    assign y2_o = y2_q;

endmodule

// File: rtl/fbosc_seq.sv
// Seeds a swap pair, runs a counted number of swaps with stall, then pulses done.
// Optional: FBOSC_SEQ_AUTORESTART_EN lets start in DONE begin the next run directly.
module fbosc_seq
    import fbosc_seq_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     seed1,
    input  logic [W-1:0]     seed2,
    input  logic [CNT_W-1:0] cycles,
    input  logic             hold,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     y1,
    output logic [W-1:0]     y2,
    output logic [CNT_W-1:0] swaps
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] swaps_q, swaps_d;
    logic             load, swap;
    logic             last_swap;

    // Compare one bit wider so the all-ones count terminates before any wrap.
    assign last_swap = ({1'b0, swaps_q} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, cnt_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            swaps_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            swaps_q <= swaps_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (cycles != '0) ? RUN : DONE;
            RUN:  if (!hold && last_swap) state_d = DONE;
            DONE: begin
`ifdef FBOSC_SEQ_AUTORESTART_EN
                if (start) state_d = (cycles != '0) ? RUN : DONE;
                else       state_d = IDLE;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
`ifdef FBOSC_SEQ_AUTORESTART_EN
        load = start && ((state_q == IDLE) || (state_q == DONE));
`else
        load = start && (state_q == IDLE);
`endif
        swap = (state_q == RUN) && !hold;
    end

    always_comb begin
        cnt_d   = cnt_q;
        swaps_d = swaps_q;
        if (load) begin
            cnt_d   = cycles;
            swaps_d = '0;
        end else if (swap) begin
            swaps_d = swaps_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    fbosc_pair #(.W(W)) u_pair (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (load),
        .swap_i  (swap),
        .seed1_i (seed1),
        .seed2_i (seed2),
        .y1_o    (y1),
        .y2_o    (y2)
    );

    assign swaps = swaps_q;

endmodule

// File: tb/tb_fbosc_seq.sv
// Directed self-checking bench for fbosc_seq; define FBOSC_SEQ_AUTORESTART_EN to cover back-to-back restart.
module tb_fbosc_seq;

    logic       clk = 1'b0;
    logic       rst, start, hold;
    logic [7:0] seed1, seed2, cycles;
    logic       busy, done;
    logic [7:0] y1, y2, swaps;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fbosc_seq #(.W(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .seed1(seed1), .seed2(seed2),
        .cycles(cycles), .hold(hold), .busy(busy), .done(done),
        .y1(y1), .y2(y2), .swaps(swaps)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; hold = 1'b0;
        seed1 = 8'h00; seed2 = 8'h00; cycles = 8'h00;
        step(); step();
        total++; if (y1 !== 8'h00) begin bad++; $display("FAIL reset_y1 got=%h exp=00", y1); end
        total++; if (y2 !== 8'hFF) begin bad++; $display("FAIL reset_y2 got=%h exp=FF", y2); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (swaps !== 8'h00) begin bad++; $display("FAIL reset_swaps got=%h exp=00", swaps); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_odd();
        logic [7:0] ey1 [4] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
        logic [7:0] ey2 [4] = '{8'h3C, 8'hA5, 8'h3C, 8'hA5};
        seed1 = 8'hA5; seed2 = 8'h3C; cycles = 8'd3; start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            start = 1'b0;
            total++; if (y1 !== ey1[k] || y2 !== ey2[k]) begin
                bad++; $display("FAIL odd_pair%0d got=%h/%h exp=%h/%h", k, y1, y2, ey1[k], ey2[k]);
            end
            total++; if (busy !== (k < 3)) begin
                bad++; $display("FAIL odd_busy%0d got=%b exp=%b", k, busy, (k < 3));
            end
            total++; if (done !== (k == 3)) begin
                bad++; $display("FAIL odd_done%0d got=%b exp=%b", k, done, (k == 3));
            end
        end
        total++; if (swaps !== 8'd3) begin bad++; $display("FAIL odd_swaps got=%0d exp=3", swaps); end
        step();
        total++; if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL odd_idle got done=%b busy=%b exp 0/0", done, busy);
        end
        total++; if (y1 !== 8'h3C || y2 !== 8'hA5 || swaps !== 8'd3) begin
            bad++; $display("FAIL odd_hold got=%h/%h/%0d exp=3C/A5/3", y1, y2, swaps);
        end
    endtask

    task automatic test_zero();
        seed1 = 8'h11; seed2 = 8'h22; cycles = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        total++; if (y1 !== 8'h11 || y2 !== 8'h22) begin
            bad++; $display("FAIL zero_pair got=%h/%h exp=11/22", y1, y2);
        end
        total++; if (done !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL zero_done got done=%b busy=%b exp 1/0", done, busy);
        end
        total++; if (swaps !== 8'd0) begin bad++; $display("FAIL zero_swaps got=%0d exp=0", swaps); end
        step();
        total++; if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL zero_after got done=%b busy=%b exp 0/0", done, busy);
        end
    endtask

    task automatic test_stall();
        seed1 = 8'h5A; seed2 = 8'hC3; cycles = 8'd4; start = 1'b1; hold = 1'b0;
        step();
        start = 1'b0;
        step();
        total++; if (swaps !== 8'd1) begin bad++; $display("FAIL stall_first got=%0d exp=1", swaps); end
        hold = 1'b1;
        step(); step();
        total++; if (swaps !== 8'd1 || y1 !== 8'hC3 || y2 !== 8'h5A || busy !== 1'b1) begin
            bad++; $display("FAIL stall_frozen got=%0d %h/%h busy=%b exp=1 C3/5A busy=1", swaps, y1, y2, busy);
        end
        hold = 1'b0;
        step(); step();
        total++; if (swaps !== 8'd3 || busy !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL stall_run got=%0d busy=%b done=%b exp=3 1 0", swaps, busy, done);
        end
        step();
        total++; if (done !== 1'b1 || swaps !== 8'd4 || y1 !== 8'h5A || y2 !== 8'hC3) begin
            bad++; $display("FAIL stall_end got done=%b %0d %h/%h exp 1 4 5A/C3", done, swaps, y1, y2);
        end
        step();
    endtask

    task automatic test_hold_terminal();
        seed1 = 8'h77; seed2 = 8'h77; cycles = 8'd1; start = 1'b1; hold = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        total++; if (busy !== 1'b1 || done !== 1'b0 || swaps !== 8'd0) begin
            bad++; $display("FAIL holdterm_wait got busy=%b done=%b %0d exp 1 0 0", busy, done, swaps);
        end
        hold = 1'b0;
        step();
        total++; if (done !== 1'b1 || swaps !== 8'd1 || y1 !== 8'h77 || y2 !== 8'h77) begin
            bad++; $display("FAIL holdterm_end got done=%b %0d %h/%h exp 1 1 77/77", done, swaps, y1, y2);
        end
        step();
    endtask

    task automatic test_reset_mid();
        seed1 = 8'h12; seed2 = 8'h34; cycles = 8'd5; start = 1'b1;
        step();
        step();
        total++; if (y1 !== 8'h34 || y2 !== 8'h12 || swaps !== 8'd1) begin
            bad++; $display("FAIL rstmid_ignore_start got=%h/%h %0d exp=34/12 1", y1, y2, swaps);
        end
        rst = 1'b1; start = 1'b0;
        step();
        rst = 1'b0;
        total++; if (y1 !== 8'h00 || y2 !== 8'hFF || swaps !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL rstmid_vals got=%h/%h %0d busy=%b done=%b exp=00/FF 0 0 0", y1, y2, swaps, busy, done);
        end
        step();
        total++; if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_nodone got done=%b busy=%b exp 0/0", done, busy);
        end
    endtask

    task automatic test_full();
        int nbusy = 0;
        int n = 0;
        seed1 = 8'h01; seed2 = 8'h80; cycles = 8'hFF; start = 1'b1;
        step();
        start = 1'b0;
        while (busy === 1'b1 && n < 400) begin
            nbusy++; n++;
            step();
        end
        total++; if (nbusy !== 255) begin bad++; $display("FAIL full_busy got=%0d exp=255", nbusy); end
        total++; if (done !== 1'b1 || swaps !== 8'hFF || y1 !== 8'h80 || y2 !== 8'h01) begin
            bad++; $display("FAIL full_end got done=%b %0d %h/%h exp 1 255 80/01", done, swaps, y1, y2);
        end
        step();
    endtask

    task automatic test_back_to_back();
        seed1 = 8'h01; seed2 = 8'h02; cycles = 8'd1; start = 1'b1;
        step();
        seed1 = 8'h0A; seed2 = 8'h0B;
        step();
        total++; if (done !== 1'b1 || y1 !== 8'h02 || y2 !== 8'h01) begin
            bad++; $display("FAIL b2b_done got done=%b %h/%h exp 1 02/01", done, y1, y2);
        end
        step();
`ifdef FBOSC_SEQ_AUTORESTART_EN
        total++; if (busy !== 1'b1 || y1 !== 8'h0A || y2 !== 8'h0B || swaps !== 8'd0) begin
            bad++; $display("FAIL b2b_restart got busy=%b %h/%h %0d exp 1 0A/0B 0", busy, y1, y2, swaps);
        end
`else
        total++; if (busy !== 1'b0 || done !== 1'b0 || y1 !== 8'h02 || y2 !== 8'h01) begin
            bad++; $display("FAIL b2b_idle got busy=%b done=%b %h/%h exp 0 0 02/01", busy, done, y1, y2);
        end
        step();
        total++; if (busy !== 1'b1 || y1 !== 8'h0A || y2 !== 8'h0B || swaps !== 8'd0) begin
            bad++; $display("FAIL b2b_restart got busy=%b %h/%h %0d exp 1 0A/0B 0", busy, y1, y2, swaps);
        end
`endif
        start = 1'b0;
        step();
        total++; if (done !== 1'b1 || y1 !== 8'h0B || y2 !== 8'h0A || swaps !== 8'd1) begin
            bad++; $display("FAIL b2b_second got done=%b %h/%h %0d exp 1 0B/0A 1", done, y1, y2, swaps);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_odd();
        test_zero();
        test_stall();
        test_hold_terminal();
        test_reset_mid();
        test_full();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fbosc_seq.md
Name: fbosc_seq

Overview:
- Sequencer for a two-register feedback swap pair, held internally as outputs y1 and y2.
- Each enabled cycle, y1 takes the old y2 and y2 takes the old y1.
- The block seeds the pair, runs a programmed number of swaps with stall support, then signals completion.
- Used wherever the team needs a controlled, countable oscillation instead of a free-running one.

Parameters:
- W, 8, data width of each register in the pair.
- CNT_W, 8, width of the swap count and its counter.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to seed the pair and begin a run; sampled only in IDLE.
- seed1  input  W  initial value for y1; captured with start.
- seed2  input  W  initial value for y2; captured with start.
- cycles  input  CNT_W  number of swaps to perform; captured with start.
- hold  input  1  stall; while high in RUN, no swap and no count.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse; high while in DONE.
- y1  output  W  pair register 1.
- y2  output  W  pair register 2.
- swaps  output  CNT_W  swaps completed in the current or last run.

Behaviour:
- Reset:
  - Clock and reset are fixed: one clock, clk; reset rst is synchronous and active-high.
  - On rst=1 at an edge: state=IDLE, y1=0, y2={W{1'b1}} (reset/preset pair), swaps=0, busy=0, done=0, latched count=0.
  - rst has priority over all other inputs in every state.
- States: IDLE, RUN, DONE. Outputs are decoded from registered state: busy=(state==RUN), done=(state==DONE).
- IDLE:
  - start=0: y1, y2 and swaps hold.
  - start=1 at edge: y1<=seed1, y2<=seed2, latched count<=cycles, swaps<=0.
  - Next state is RUN if cycles!=0, else DONE.
- RUN:
  - hold=0 at edge: y1<=y2 and y2<=y1 simultaneously, using old values; swaps<=swaps+1.
  - If swaps+1==latched count, next state is DONE.
  - hold=1: no change to the pair, swaps or state.
  - start is ignored in RUN.
- DONE:
  - Lasts exactly one cycle, then IDLE.
  - y1, y2 and swaps hold their final values into IDLE until the next start.
- Latency, with start high at edge E and no holds:
  - Seeds are visible after E and busy=1.
  - The k-th swap occurs at edge E+k.
  - done=1 in the cycle after edge E+N; busy=0 in that cycle.
  - Total start-to-done is N+1 edges.
- Boundaries:
  - cycles=0: seeds are loaded and done pulses in the cycle after E; no swap occurs.
  - cycles=2^CNT_W-1: full count. The counter never wraps because the terminal compare precedes any increment.
  - hold asserted on the terminal cycle delays DONE until hold drops.
  - rst mid-RUN: the next cycle shows reset values, with no done pulse.
  - seed1==seed2: legal; swaps still count normally.

Optional Feature:
- Macro: FBOSC_SEQ_AUTORESTART_EN.
- Defined: start=1 sampled in DONE reloads seeds, latched count and swaps exactly as in IDLE. Next state is RUN, or DONE if cycles=0. This allows back-to-back runs with no IDLE gap; done still pulses per run.
- Undefined: start in DONE is ignored, and the block always passes through IDLE for at least one cycle.

Decomposition:
- Package fbosc_seq_pkg holds:
  - the state typedef (2-bit enum: IDLE=0, RUN=1, DONE=2);
  - reset constants Y1_RST=0 and Y2_RST=all-ones, as width-parameterised functions or localparams.
- Sub-module fbosc_pair holds the two W-bit registers plus load and swap enables. It has no state machine. The controller drives load/swap and owns the counter and FSM.

Test Plan:
- Reset check: rst=1 for 2 cycles → y1=8'h00, y2=8'hFF, busy=0, done=0, swaps=0.
- Odd count: start with seed1=8'hA5, seed2=8'h3C, cycles=3, hold=0 → after each edge (y1,y2)=(A5,3C),(3C,A5),(A5,3C),(3C,A5). Then done=1 for exactly one cycle, swaps=3, busy high for 3 cycles.
- Zero count: start with cycles=0, seeds 8'h11/8'h22 → y1=11, y2=22, done pulses the next cycle, swaps=0, busy never high.
- Stall: cycles=4, hold=1 during the 2nd and 3rd RUN cycles → done 2 cycles later than unstalled, final (y1,y2)=seeds, swaps=4.
- Reset mid-op: rst=1 during swap 2 of cycles=5 → next cycle y1=00, y2=FF, state IDLE, no done pulse. start is ignored in RUN throughout.
- Back-to-back start: start held high through DONE. Without the macro: one IDLE cycle, then a new run. With FBOSC_SEQ_AUTORESTART_EN: RUN follows DONE directly, and seeds reload in the same edge.
